// File: rtl/ram_4x8_arbiter.sv
// Two-port round-robin arbiter that sequences single read/write transactions onto one ram_4x8.
// Writes occupy two cycles (IDLE, ACCESS); reads occupy three (IDLE, ACCESS, RESP).
module ram_4x8_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              rw_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              req_1,
  input  logic              rw_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic                prio;
  logic                owner;
  logic                any_req;
  logic                sel;
  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Contention goes to prio; a lone requester wins regardless of prio.
  always_comb begin
    any_req   = req_0 | req_1;
    sel       = (req_0 && req_1) ? prio : req_1;
    sel_rw    = sel ? rw_1    : rw_0;
    sel_addr  = sel ? addr_1  : addr_0;
    sel_wdata = sel ? wdata_1 : wdata_0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      owner       <= 1'b0;
      ram_rw      <= 1'b1;
      ram_addr    <= '0;
      ram_data_in <= '0;
      gnt_0       <= 1'b0;
      gnt_1       <= 1'b0;
      rvalid_0    <= 1'b0;
      rvalid_1    <= 1'b0;
      rdata_0     <= '0;
      rdata_1     <= '0;
    end else begin
      gnt_0    <= 1'b0;
      gnt_1    <= 1'b0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            ram_rw      <= sel_rw;
            ram_addr    <= sel_addr;
            ram_data_in <= sel_wdata;
            gnt_0       <= ~sel;
            gnt_1       <= sel;
            owner       <= sel;
            prio        <= ~sel;
            state       <= ACCESS;
          end
        end
        // ram_rw still holds the accepted direction here, so it doubles as the read flag.
        ACCESS: begin
          if (ram_rw) begin
            state <= RESP;
          end else begin
            ram_rw <= 1'b1;
            state  <= IDLE;
          end
        end
        RESP: begin
          if (owner) begin
            rdata_1  <= ram_data_out;
            rvalid_1 <= 1'b1;
          end else begin
            rdata_0  <= ram_data_out;
            rvalid_0 <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_4x8_arbiter.sv
// Bench for ram_4x8_arbiter: a stand-in ram_4x8 plus a transaction-level schedule model
// that predicts grant/rvalid cycles, RAM drive and read data from the arbitration rules.
module tb_ram_4x8_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_0 = 1'b0, rw_0 = 1'b1, req_1 = 1'b0, rw_1 = 1'b1;
  logic [2:0] addr_0 = '0, addr_1 = '0;
  logic [3:0] wdata_0 = '0, wdata_1 = '0;
  logic       gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [3:0] rdata_0, rdata_1;
  logic       ram_rw;
  logic [2:0] ram_addr;
  logic [3:0] ram_data_in;
  logic [3:0] ram_data_out = '0;
  logic [3:0] ram_mem [8];

  ram_4x8_arbiter #(.ADDR_W(3), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .rw_0(rw_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req_1), .rw_1(rw_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural ram_4x8: write on rw=0, registered read on rw=1.
  always @(posedge clk) begin
    if (!ram_rw) ram_mem[ram_addr] <= ram_data_in;
    else         ram_data_out      <= ram_mem[ram_addr];
  end

  typedef struct {
    bit         rd;
    logic [2:0] addr;
    logic [3:0] wdata;
    int         gap;
  } txn_t;

  int   total = 0;
  int   bad = 0;
  int   c = 0;
  txn_t q0[$];
  txn_t q1[$];
  int   gnt_log[$];

  // Schedule model: when the arbiter is free, the next grant/rvalid/write cycles follow.
  int         free_at, gnt_at, wr_at, rv_at;
  bit         gnt_port, rv_port, prio_m;
  logic [3:0] rv_data, acc_data;
  logic [2:0] acc_addr;
  logic [3:0] ref_mem [8];
  logic [3:0] exp_rd [2];
  int         gap_left [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  always @(negedge clk) begin
    chk("gnt_exclusive", 32'(gnt_0 & gnt_1), 32'(0));
    chk("rvalid_exclusive", 32'(rvalid_0 & rvalid_1), 32'(0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    c++;
  endtask

  function automatic txn_t mk(input bit rd, input int a, input int d, input int g);
    txn_t t;
    t.rd = rd;
    t.addr = 3'(a);
    t.wdata = 4'(d);
    t.gap = g;
    return t;
  endfunction

  task automatic model_reset();
    free_at  = c;
    gnt_at   = -1;
    wr_at    = -1;
    rv_at    = -1;
    prio_m   = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_rw"}, 32'(ram_rw), 32'(1));
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(0));
    chk({tag, "_ram_data_in"}, 32'(ram_data_in), 32'(0));
    chk({tag, "_gnt_0"}, 32'(gnt_0), 32'(0));
    chk({tag, "_gnt_1"}, 32'(gnt_1), 32'(0));
    chk({tag, "_rvalid_0"}, 32'(rvalid_0), 32'(0));
    chk({tag, "_rvalid_1"}, 32'(rvalid_1), 32'(0));
    chk({tag, "_rdata_0"}, 32'(rdata_0), 32'(0));
    chk({tag, "_rdata_1"}, 32'(rdata_1), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_0 = 1'b0;
    req_1 = 1'b0;
    #1;
    chk_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_engine(input int min_cycles);
    int  start;
    bit  k;
    txn_t t;
    start = c;
    gap_left[0] = (q0.size() > 0) ? q0[0].gap : 0;
    gap_left[1] = (q1.size() > 0) ? q1[0].gap : 0;
    forever begin
      tick();
      if (rv_at == c) exp_rd[rv_port] = rv_data;
      chk("gnt_0", 32'(gnt_0), 32'(gnt_at == c && gnt_port == 1'b0));
      chk("gnt_1", 32'(gnt_1), 32'(gnt_at == c && gnt_port == 1'b1));
      chk("rvalid_0", 32'(rvalid_0), 32'(rv_at == c && rv_port == 1'b0));
      chk("rvalid_1", 32'(rvalid_1), 32'(rv_at == c && rv_port == 1'b1));
      chk("rdata_0", 32'(rdata_0), 32'(exp_rd[0]));
      chk("rdata_1", 32'(rdata_1), 32'(exp_rd[1]));
      chk("ram_rw", 32'(ram_rw), 32'(wr_at == c ? 0 : 1));
      if (gnt_at == c) begin
        chk("ram_addr", 32'(ram_addr), 32'(acc_addr));
        if (wr_at == c) chk("ram_data_in", 32'(ram_data_in), 32'(acc_data));
      end
      if (gnt_0) gnt_log.push_back(0);
      if (gnt_1) gnt_log.push_back(1);
      if (q0.size() == 0 && q1.size() == 0 && c >= free_at && c - start >= min_cycles) break;

      // Requesters: count down the idle gap, then hold the head transaction until granted.
      if (q0.size() > 0 && gap_left[0] > 0) begin req_0 = 1'b0; gap_left[0]--; end
      else if (q0.size() > 0) begin
        req_0 = 1'b1; rw_0 = q0[0].rd; addr_0 = q0[0].addr; wdata_0 = q0[0].wdata;
      end else req_0 = 1'b0;
      if (q1.size() > 0 && gap_left[1] > 0) begin req_1 = 1'b0; gap_left[1]--; end
      else if (q1.size() > 0) begin
        req_1 = 1'b1; rw_1 = q1[0].rd; addr_1 = q1[0].addr; wdata_1 = q1[0].wdata;
      end else req_1 = 1'b0;

      if (c >= free_at && (req_0 || req_1)) begin
        k = (req_0 && req_1) ? prio_m : req_1;
        if (k) begin
          t = q1.pop_front();
          gap_left[1] = (q1.size() > 0) ? q1[0].gap : 0;
        end else begin
          t = q0.pop_front();
          gap_left[0] = (q0.size() > 0) ? q0[0].gap : 0;
        end
        gnt_at   = c + 1;
        gnt_port = k;
        acc_addr = t.addr;
        acc_data = t.wdata;
        if (t.rd) begin
          rv_at   = c + 3;
          rv_port = k;
          rv_data = ref_mem[t.addr];
          wr_at   = -1;
          free_at = c + 3;
        end else begin
          ref_mem[t.addr] = t.wdata;
          wr_at   = c + 1;
          free_at = c + 2;
        end
        prio_m = ~k;
      end
    end
    req_0 = 1'b0;
    req_1 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    tick();
    do_reset();

    // Idle after reset: RAM held in read of address 0, no handshakes.
    repeat (10) begin
      tick();
      chk_reset_outputs("idle");
    end

    // Port 0 write then read-back of the same address.
    q0.push_back(mk(1'b0, 3, 4'h3, 0));
    q0.push_back(mk(1'b1, 3, 0, 0));
    run_engine(2);

    // Simultaneous writes from reset: port 0 first, then read-back on both ports.
    do_reset();
    gnt_log.delete();
    q0.push_back(mk(1'b0, 0, 4'h1, 0));
    q0.push_back(mk(1'b1, 0, 0, 0));
    q1.push_back(mk(1'b0, 1, 4'h2, 0));
    q1.push_back(mk(1'b1, 1, 0, 0));
    run_engine(2);
    chk("first_grant_after_reset", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 32'(0));

    // Both ports stream reads: grants alternate 0,1,0,1,0,1.
    do_reset();
    gnt_log.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(1'b1, int'($urandom_range(0, 7)), 0, 0));
      q1.push_back(mk(1'b1, int'($urandom_range(0, 7)), 0, 0));
    end
    run_engine(2);
    chk("rr_grant_count", 32'(gnt_log.size()), 32'(6));
    for (int i = 0; i < 6; i++)
      chk("rr_grant_order", 32'(i < gnt_log.size() ? gnt_log[i] : -1), 32'(i % 2));

    // Lone port 1: back-to-back writes, then reads of the same addresses.
    for (int i = 0; i < 4; i++) q1.push_back(mk(1'b0, i, i, 0));
    for (int i = 0; i < 4; i++) q1.push_back(mk(1'b1, i, 0, 0));
    run_engine(2);

    // Random mixed traffic with idle gaps; address wraps within 3 bits.
    for (int i = 0; i < 30; i++) begin
      q0.push_back(mk(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 3))));
      q1.push_back(mk(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 3))));
    end
    run_engine(2);

    // Reset during RESP of a port 0 read: no rvalid, outputs at reset, prio back to 0.
    req_0 = 1'b1; rw_0 = 1'b1; addr_0 = 3'd5;
    tick();
    chk("abort_gnt_0", 32'(gnt_0), 32'(1));
    req_0 = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    tick();
    chk("abort_no_rvalid_0", 32'(rvalid_0), 32'(0));
    tick();
    chk("abort_no_rvalid_0_late", 32'(rvalid_0), 32'(0));
    rst_n = 1'b1;
    model_reset();
    gnt_log.delete();
    q0.push_back(mk(1'b0, 6, 4'hA, 0));
    q1.push_back(mk(1'b0, 7, 4'hB, 0));
    q0.push_back(mk(1'b1, 6, 0, 0));
    q1.push_back(mk(1'b1, 7, 0, 0));
    run_engine(2);
    chk("post_abort_first_grant", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
